memory_access_scheduler: RTL and testbench

Shares the single main-memory port (64-bit entries, fixed-depth read pipeline, multi-cycle read/write occupancy) between NUM_REQ requesters, e.g. ICache fill, DCache fill/writeback and uncached access. Each cycle it grants at most one request using round-robin arbitration. It enforces the memory's read/write process latency between accesses and assigns per-type serial IDs. It tracks in-flight reads so each returned read is tagged with the requester ID and serial. Sits between the cache-system miss handlers and the main-memory model or AXI4 bridge.

---
 rtl/memory_access_scheduler_if.sv | 47 ++++
 rtl/memory_access_scheduler.sv | 158 +++++++++++++++
 tb/tb_memory_access_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_scheduler_if.sv
// Bundle of every signal between the requesters, the scheduler and main memory.
//   slave  : the scheduler side (takes requests and read data, drives grants,
//            memory commands and tagged read responses)
//   master : the requester / memory side (the opposite directions)
// Signals:
//   reqValid/reqIsWrite  per-requester request and direction
//   reqAddr/reqWriteData packed per-requester payload (requester i = slice i)
//   reqGrant/grantSerial one-hot grant and serial of the granted request
//   memIsRead/memIsWrite/memAddr/memWriteData  memory command
//   memReadData          read data returning from memory
//   respValid/respReqId/respSerial/respData    tagged read response
interface memory_access_scheduler_if #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int SERIAL_WIDTH = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            reqValid;
  logic [NUM_REQ-1:0]            reqIsWrite;
  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr;
  logic [NUM_REQ*DATA_WIDTH-1:0] reqWriteData;
  logic [NUM_REQ-1:0]            reqGrant;
  logic [SERIAL_WIDTH-1:0]       grantSerial;
  logic                          memIsRead;
  logic                          memIsWrite;
  logic [ADDR_WIDTH-1:0]         memAddr;
  logic [DATA_WIDTH-1:0]         memWriteData;
  logic [DATA_WIDTH-1:0]         memReadData;
  logic                          respValid;
  logic [ID_W-1:0]               respReqId;
  logic [SERIAL_WIDTH-1:0]       respSerial;
  logic [DATA_WIDTH-1:0]         respData;

  modport slave (
    input  reqValid, reqIsWrite, reqAddr, reqWriteData, memReadData,
    output reqGrant, grantSerial, memIsRead, memIsWrite, memAddr, memWriteData,
           respValid, respReqId, respSerial, respData
  );

  modport master (
    output reqValid, reqIsWrite, reqAddr, reqWriteData, memReadData,
    input  reqGrant, grantSerial, memIsRead, memIsWrite, memAddr, memWriteData,
           respValid, respReqId, respSerial, respData
  );
endinterface

// File: rtl/memory_access_scheduler.sv
// Round-robin scheduler sharing one main-memory port between NUM_REQ
// requesters. Grants at most one request per cycle, spaces issues by the
// read/write process latency, hands out independent read and write serials
// and tags every returning read with its requester and serial.
// Ports:
//   clk  clock
//   rst  synchronous, active-low reset
//   bus  scheduler side of memory_access_scheduler_if (requests, grants,
//        memory command, read data and tagged read responses)
module memory_access_scheduler #(
  parameter int NUM_REQ         = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int READ_PIPE_DEPTH = 5,
  parameter int READ_PROC_LAT   = 2,
  parameter int WRITE_PROC_LAT  = 2,
  parameter int SERIAL_WIDTH    = 4
) (
  input logic                      clk,
  input logic                      rst,
  memory_access_scheduler_if.slave bus
);
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int SUM_W   = ID_W + 1;
  localparam int MAX_LAT = (READ_PROC_LAT > WRITE_PROC_LAT) ? READ_PROC_LAT : WRITE_PROC_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int LAST    = READ_PIPE_DEPTH - 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [SERIAL_WIDTH-1:0] rd_ser_q, rd_ser_d;
  logic [SERIAL_WIDTH-1:0] wr_ser_q, wr_ser_d;

  logic                    found;
  logic [ID_W-1:0]         gidx;
  logic [SUM_W-1:0]        cand;
  logic                    issue;
  logic                    issue_wr;

  // In-flight read tracker, one entry per read-pipeline cycle
  logic [READ_PIPE_DEPTH-1:0] trk_vld_q;
  logic [ID_W-1:0]            trk_id_q  [READ_PIPE_DEPTH];
  logic [SERIAL_WIDTH-1:0]    trk_ser_q [READ_PIPE_DEPTH];
  logic                       rsp_v;

  // Round-robin search starting at the pointer; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) cand = cand - SUM_W'(NUM_REQ);
      if (!found && bus.reqValid[cand[ID_W-1:0]]) begin
        found = 1'b1;
        gidx  = cand[ID_W-1:0];
      end
    end
  end

  // Grant / command decode and next-state logic. Outputs are held at zero
  // while rst is low so nothing leaks out during the reset cycle.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    ptr_d            = ptr_q;
    rd_ser_d         = rd_ser_q;
    wr_ser_d         = wr_ser_q;
    issue            = 1'b0;
    issue_wr         = 1'b0;
    bus.reqGrant     = '0;
    bus.grantSerial  = '0;
    bus.memIsRead    = 1'b0;
    bus.memIsWrite   = 1'b0;
    bus.memAddr      = '0;
    bus.memWriteData = '0;
    unique case (state_q)
      IDLE: begin
        if (rst && found) begin
          issue              = 1'b1;
          issue_wr           = bus.reqIsWrite[gidx];
          bus.reqGrant[gidx] = 1'b1;
          bus.memIsRead      = !issue_wr;
          bus.memIsWrite     = issue_wr;
          bus.memAddr        = bus.reqAddr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
          bus.memWriteData   = bus.reqWriteData[gidx*DATA_WIDTH +: DATA_WIDTH];
          if (issue_wr) begin
            bus.grantSerial = wr_ser_q;
            wr_ser_d        = wr_ser_q + 1'b1;
          end else begin
            bus.grantSerial = rd_ser_q;
            rd_ser_d        = rd_ser_q + 1'b1;
          end
          ptr_d = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          // Latency 1 needs no blackout; otherwise wait L-1 cycles in BUSY.
          if (issue_wr && (WRITE_PROC_LAT > 1)) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(WRITE_PROC_LAT - 1);
          end else if (!issue_wr && (READ_PROC_LAT > 1)) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(READ_PROC_LAT - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      rd_ser_q <= '0;
      wr_ser_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      rd_ser_q <= rd_ser_d;
      wr_ser_q <= wr_ser_d;
    end
  end

  // Tracker: stage 0 captures a read grant, every stage shifts each cycle,
  // so the last stage lines up with memReadData READ_PIPE_DEPTH cycles later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      trk_vld_q <= '0;
      for (int k = 0; k < READ_PIPE_DEPTH; k++) begin
        trk_id_q[k]  <= '0;
        trk_ser_q[k] <= '0;
      end
    end else begin
      trk_vld_q[0] <= issue & ~issue_wr;
      trk_id_q[0]  <= gidx;
      trk_ser_q[0] <= rd_ser_q;
      for (int k = 1; k < READ_PIPE_DEPTH; k++) begin
        trk_vld_q[k] <= trk_vld_q[k-1];
        trk_id_q[k]  <= trk_id_q[k-1];
        trk_ser_q[k] <= trk_ser_q[k-1];
      end
    end
  end

  assign rsp_v          = rst & trk_vld_q[LAST];
  assign bus.respValid  = rsp_v;
  assign bus.respReqId  = rsp_v ? trk_id_q[LAST]  : '0;
  assign bus.respSerial = rsp_v ? trk_ser_q[LAST] : '0;
  assign bus.respData   = rsp_v ? bus.memReadData : '0;
endmodule

// File: tb/tb_memory_access_scheduler.sv
`timescale 1ns/1ps
module tb_memory_access_scheduler;
  localparam int NUM_REQ = 3;
  localparam int AW      = 32;
  localparam int DW      = 64;
  localparam int SW      = 4;
  localparam int DEPTH   = 5;
  localparam int RLAT_A  = 2;
  localparam int WLAT_A  = 2;
  localparam int RLAT_B  = 1;
  localparam int WLAT_B  = 3;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int WAIT_BOUND = NUM_REQ * 3 + 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  memory_access_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW)) ifa ();
  memory_access_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW)) ifb ();

  memory_access_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_PIPE_DEPTH(DEPTH),
    .READ_PROC_LAT(RLAT_A), .WRITE_PROC_LAT(WLAT_A), .SERIAL_WIDTH(SW))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  memory_access_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_PIPE_DEPTH(DEPTH),
    .READ_PROC_LAT(RLAT_B), .WRITE_PROC_LAT(WLAT_B), .SERIAL_WIDTH(SW))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Both instances see the same stimulus; sel picks the one being checked.
  logic [NUM_REQ-1:0]    req_v = '0, req_w = '0;
  logic [NUM_REQ*AW-1:0] req_a = '0;
  logic [NUM_REQ*DW-1:0] req_d = '0;
  logic [DW-1:0]         mem_rd = '0;
  logic                  sel = 1'b0;

  assign ifa.reqValid = req_v;  assign ifb.reqValid = req_v;
  assign ifa.reqIsWrite = req_w; assign ifb.reqIsWrite = req_w;
  assign ifa.reqAddr = req_a;   assign ifb.reqAddr = req_a;
  assign ifa.reqWriteData = req_d; assign ifb.reqWriteData = req_d;
  assign ifa.memReadData = mem_rd; assign ifb.memReadData = mem_rd;

  logic [NUM_REQ-1:0] o_grant;
  logic [SW-1:0]      o_gser, o_rser;
  logic               o_mrd, o_mwr, o_rv;
  logic [AW-1:0]      o_maddr;
  logic [DW-1:0]      o_mwdata, o_rdata;
  logic [ID_W-1:0]    o_rid;
  assign o_grant  = sel ? ifb.reqGrant     : ifa.reqGrant;
  assign o_gser   = sel ? ifb.grantSerial  : ifa.grantSerial;
  assign o_mrd    = sel ? ifb.memIsRead    : ifa.memIsRead;
  assign o_mwr    = sel ? ifb.memIsWrite   : ifa.memIsWrite;
  assign o_maddr  = sel ? ifb.memAddr      : ifa.memAddr;
  assign o_mwdata = sel ? ifb.memWriteData : ifa.memWriteData;
  assign o_rv     = sel ? ifb.respValid    : ifa.respValid;
  assign o_rid    = sel ? ifb.respReqId    : ifa.respReqId;
  assign o_rser   = sel ? ifb.respSerial   : ifa.respSerial;
  assign o_rdata  = sel ? ifb.respData     : ifa.respData;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s @cycle %0d", name, cyc);
  endfunction

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  function automatic int rlat();
    return sel ? RLAT_B : RLAT_A;
  endfunction
  function automatic int wlat();
    return sel ? WLAT_B : WLAT_A;
  endfunction

  // Pending (level-held) requests per requester
  bit            pv[NUM_REQ], pw[NUM_REQ];
  logic [AW-1:0] pa[NUM_REQ];
  logic [DW-1:0] pd[NUM_REQ];
  int            pt[NUM_REQ];
  bit            hold[NUM_REQ];
  bit            dir_v[NUM_REQ], dir_w[NUM_REQ];
  logic [AW-1:0] dir_a[NUM_REQ];
  logic [DW-1:0] dir_d[NUM_REQ];
  int            rand_pct = 0;
  int            rst_cnt = 0;
  int            last_g = -1;

  // Scoreboard queues
  typedef struct { int cyc; int g; bit w; logic [AW-1:0] a; logic [DW-1:0] d; int ser; } gexp_t;
  typedef struct { int cyc; int id; int ser; logic [DW-1:0] d; } rexp_t;
  typedef struct { int cyc; logic [DW-1:0] d; } epipe_t;
  gexp_t gq[$];
  rexp_t rq[$];
  epipe_t eq[$];

  // Reference model: time-based spacing, plain round-robin, integer serials
  int m_ptr = 0, m_next = 0, m_rser = 0, m_wser = 0;
  logic [DW-1:0] m_mem [logic [AW-1:0]];
  logic [DW-1:0] e_mem [logic [AW-1:0]];

  function automatic void model_cycle(int c);
    int g;
    int lat;
    logic [DW-1:0] d;
    if (!rst) begin
      m_ptr = 0; m_rser = 0; m_wser = 0; m_next = c + 1;
      while (rq.size() > 0 && rq[$].cyc >= c) void'(rq.pop_back());
      return;
    end
    if (c < m_next) return;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (g < 0 && pv[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
    if (g < 0) return;
    if (pw[g]) begin
      gq.push_back('{c, g, 1'b1, pa[g], pd[g], m_wser});
      m_mem[pa[g]] = pd[g];
      m_wser = (m_wser + 1) % (1 << SW);
      lat = wlat();
    end else begin
      gq.push_back('{c, g, 1'b0, pa[g], pd[g], m_rser});
      d = m_mem.exists(pa[g]) ? m_mem[pa[g]] : init_val(pa[g]);
      rq.push_back('{c + DEPTH, g, m_rser, d});
      m_rser = (m_rser + 1) % (1 << SW);
      lat = rlat();
    end
    m_ptr = (g + 1) % NUM_REQ;
    m_next = c + lat;
  endfunction

  task automatic step(int n);
    int c;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      c = cyc;
      if (last_g >= 0) begin
        chk("wait_bound", 64'(((c - 1 - pt[last_g]) <= WAIT_BOUND) ? 1 : 0), 64'(1));
        pv[last_g] = 1'b0;
      end
      if (rst_cnt > 0) begin rst = 1'b0; rst_cnt--; end
      else rst = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (dir_v[r] && !pv[r]) begin
          pv[r] = 1'b1; pw[r] = dir_w[r]; pa[r] = dir_a[r]; pd[r] = dir_d[r]; pt[r] = c;
          dir_v[r] = 1'b0;
        end
        if (!pv[r] && (hold[r] || ($urandom_range(0, 99) < rand_pct))) begin
          pv[r] = 1'b1;
          pw[r] = hold[r] ? 1'b0 : ($urandom_range(0, 99) < 40);
          pa[r] = AW'($urandom_range(0, 15) * 8);
          pd[r] = {$urandom, $urandom};
          pt[r] = c;
        end
        req_v[r] = pv[r];
        req_w[r] = pw[r];
        req_a[r*AW +: AW] = pa[r];
        req_d[r*DW +: DW] = pd[r];
      end
      while (eq.size() > 0 && eq[0].cyc < c) void'(eq.pop_front());
      if (eq.size() > 0 && eq[0].cyc == c) mem_rd = eq.pop_front().d;
      else mem_rd = {$urandom, $urandom};
      model_cycle(c);
    end
  endtask

  task automatic direct(int r, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    dir_v[r] = 1'b1; dir_w[r] = w; dir_a[r] = a; dir_d[r] = d;
  endtask

  // Monitor: samples mid-cycle, acts as the memory, pops expectations
  initial begin : monitor
    int c;
    int g;
    gexp_t e;
    rexp_t re;
    @(posedge clk);
    forever begin
      @(negedge clk);
      c = cyc;
      last_g = -1;
      if (!rst) begin
        chk("reset_outputs", 64'(|{o_grant, o_gser, o_mrd, o_mwr, o_maddr, o_mwdata, o_rv, o_rid, o_rser, o_rdata}), 64'(0));
      end else begin
        if (o_grant != '0) begin
          g = -1;
          for (int k = 0; k < NUM_REQ; k++) if (o_grant[k]) g = k;
          chk("grant_onehot", 64'($countones(o_grant)), 64'(1));
          if ($countones(o_grant) == 1) last_g = g;
          if (o_mwr) e_mem[o_maddr] = o_mwdata;
          if (o_mrd) eq.push_back('{c + DEPTH, e_mem.exists(o_maddr) ? e_mem[o_maddr] : init_val(o_maddr)});
          if (gq.size() == 0) fail_now("grant_unexpected");
          else begin
            e = gq.pop_front();
            chk("grant_cycle", 64'(c), 64'(e.cyc));
            chk("grant_vector", 64'(o_grant), 64'(1) << e.g);
            chk("grant_cmd", 64'({o_mrd, o_mwr}), 64'({!e.w, e.w}));
            chk("grant_addr", 64'(o_maddr), 64'(e.a));
            chk("grant_wdata", o_mwdata, e.d);
            chk("grant_serial", 64'(o_gser), 64'(e.ser));
          end
        end else begin
          if (gq.size() > 0 && gq[0].cyc <= c) begin
            fail_now("grant_missing");
            void'(gq.pop_front());
          end
          chk("idle_cmd", 64'({o_mrd, o_mwr}), 64'(0));
        end
        if (o_rv) begin
          if (rq.size() == 0) fail_now("resp_unexpected");
          else begin
            re = rq.pop_front();
            chk("resp_cycle", 64'(c), 64'(re.cyc));
            chk("resp_id", 64'(o_rid), 64'(re.id));
            chk("resp_serial", 64'(o_rser), 64'(re.ser));
            chk("resp_data", o_rdata, re.d);
          end
        end else if (rq.size() > 0 && rq[0].cyc <= c) begin
          fail_now("resp_missing");
          void'(rq.pop_front());
        end
      end
    end
  end

  task automatic do_reset(int n);
    rst_cnt = n;
    step(n);
  endtask

  initial begin : stimulus
    for (int r = 0; r < NUM_REQ; r++) begin
      pv[r] = 0; pw[r] = 0; pa[r] = '0; pd[r] = '0; pt[r] = 0; hold[r] = 0; dir_v[r] = 0;
      dir_w[r] = 0; dir_a[r] = '0; dir_d[r] = '0;
    end
    do_reset(3);

    // Single read from requester 1
    direct(1, 1'b0, 32'h100, 64'h0);
    step(10);

    // All three requesters reading continuously from reset
    do_reset(1);
    for (int r = 0; r < NUM_REQ; r++) hold[r] = 1'b1;
    step(12);
    for (int r = 0; r < NUM_REQ; r++) hold[r] = 1'b0;
    step(20);

    // Write from requester 0, read of the same address from requester 2
    do_reset(1);
    direct(0, 1'b1, 32'h40, 64'hDEAD_BEEF);
    direct(2, 1'b0, 32'h40, 64'h0);
    step(12);

    // Requester 2 waits while requester 0 re-requests continuously
    hold[0] = 1'b1;
    direct(2, 1'b0, 32'h18, 64'h0);
    step(20);
    hold[0] = 1'b0;
    step(12);

    // Random traffic
    rand_pct = 40;
    step(800);
    rand_pct = 0;
    step(30);

    // Two reads in flight, then a one-cycle reset
    direct(0, 1'b0, 32'h40, 64'h0);
    direct(1, 1'b0, 32'h48, 64'h0);
    step(3);
    do_reset(1);
    step(10);
    direct(1, 1'b0, 32'h50, 64'h0);
    direct(0, 1'b0, 32'h58, 64'h0);
    step(15);

    // Second configuration: single-cycle read spacing
    sel = 1'b1;
    do_reset(2);
    hold[1] = 1'b1;
    step(18);
    hold[1] = 1'b0;
    step(12);
    rand_pct = 45;
    step(800);
    rand_pct = 0;
    step(40);

    chk("leftover_grants", 64'(gq.size()), 64'(0));
    chk("leftover_resps", 64'(rq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
